// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, branch/mispredict
// statistics and a one-entry-per-cycle clear sequence for fence.i.
module branch_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        predict_taken,
    output logic [31:0] predict_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_is_jump,
    input  logic        upd_is_jumpr,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        clear_req,
    output logic        clear_busy,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   clr_idx;
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;

    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [1:0]       u_ctr;
    logic             train;
    logic             is_jal;

    logic             ctr_we;
    logic [1:0]       ctr_nxt;
    logic             alloc;
    logic             tgt_we;

    logic             unused_bits;

    assign unused_bits = &{1'b0, if_pc[1:0], upd_pc[1:0], upd_is_jumpr};

    // Lookup is purely combinational and never sees this cycle's update.
    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[31:IDX_W+2];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign predict_taken = l_hit && ctr_q[l_idx][1] && !clear_busy;
    assign predict_pc    = predict_taken ? target_q[l_idx]
                                         : if_pc + 32'd4;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_ctr = ctr_q[u_idx];

    // JALR is never trained; a branch flag takes priority over JAL.
    assign train  = upd_valid && (upd_is_branch || upd_is_jump)
                    && !clear_busy;
    assign is_jal = !upd_is_branch && upd_is_jump;

    always_comb begin
        ctr_we  = 1'b0;
        ctr_nxt = u_ctr;
        alloc   = 1'b0;
        tgt_we  = 1'b0;
        if (train) begin
            if (u_hit && upd_taken) begin
                ctr_we  = 1'b1;
                tgt_we  = 1'b1;
                ctr_nxt = (u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'd1;
            end else if (u_hit) begin
                ctr_we  = 1'b1;
                ctr_nxt = (u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'd1;
            end else if (upd_taken) begin
                ctr_we  = 1'b1;
                alloc   = 1'b1;
                tgt_we  = 1'b1;
                ctr_nxt = is_jal ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_idx    <= '0;
            clear_busy <= 1'b0;
            valid_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        clear_busy <= 1'b1;
                    end
                    if (ctr_we) begin
                        ctr_q[u_idx] <= ctr_nxt;
                    end
                    if (alloc) begin
                        valid_q[u_idx] <= 1'b1;
                    end
                end
                CLEAR: begin
                    valid_q[clr_idx] <= 1'b0;
                    ctr_q[clr_idx]   <= 2'b01;
                    if (clr_idx == {IDX_W{1'b1}}) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Tag and target need no reset; valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && tgt_we) begin
            target_q[u_idx] <= upd_target;
        end
        if (!reset && alloc) begin
            tag_q[u_idx] <= u_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (train) begin
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (upd_mispredict && stat_mispredicts != 32'hFFFF_FFFF) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Vector-table bench for branch_predictor with an expected-value queue.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        predict_taken;
    logic [31:0] predict_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_is_jumpr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        clear_req;
    logic        clear_busy;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .predict_taken    (predict_taken),
        .predict_pc       (predict_pc),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_is_branch    (upd_is_branch),
        .upd_is_jump      (upd_is_jump),
        .upd_is_jumpr     (upd_is_jumpr),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .clear_req        (clear_req),
        .clear_busy       (clear_busy),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        clr;
        logic        uv;
        logic [2:0]  ty;
        logic        tk;
        logic        mp;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [31:0] ipc;
        logic        etk;
        logic [31:0] epc;
        logic [31:0] ebr;
        logic [31:0] emp;
        logic        ebusy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t V(string n, logic rst, logic clr, logic uv,
                               logic [2:0] ty, logic tk, logic mp,
                               logic [31:0] upc, logic [31:0] utgt,
                               logic [31:0] ipc, logic etk,
                               logic [31:0] epc, logic [31:0] ebr,
                               logic [31:0] emp, logic ebusy);
        vec_t v;
        v.name = n; v.rst = rst; v.clr = clr; v.uv = uv; v.ty = ty;
        v.tk = tk; v.mp = mp; v.upc = upc; v.utgt = utgt; v.ipc = ipc;
        v.etk = etk; v.epc = epc; v.ebr = ebr; v.emp = emp;
        v.ebusy = ebusy;
        return v;
    endfunction

    function automatic vec_t L(string n, logic [31:0] ipc, logic etk,
                               logic [31:0] epc, logic [31:0] ebr,
                               logic [31:0] emp, logic ebusy);
        return V(n, 0, 0, 0, 3'b000, 0, 0, 0, 0, ipc,
                 etk, epc, ebr, emp, ebusy);
    endfunction

    function automatic vec_t U(string n, logic [2:0] ty, logic tk,
                               logic mp, logic [31:0] upc,
                               logic [31:0] utgt, logic [31:0] ipc,
                               logic etk, logic [31:0] epc,
                               logic [31:0] ebr, logic [31:0] emp);
        return V(n, 0, 0, 1, ty, tk, mp, upc, utgt, ipc,
                 etk, epc, ebr, emp, 0);
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset          = v.rst;
        clear_req      = v.clr;
        upd_valid      = v.uv;
        upd_is_branch  = v.ty[2];
        upd_is_jump    = v.ty[1];
        upd_is_jumpr   = v.ty[0];
        upd_taken      = v.tk;
        upd_mispredict = v.mp;
        upd_pc         = v.upc;
        upd_target     = v.utgt;
        if_pc          = v.ipc;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        total++;
        if (predict_taken !== e.etk || predict_pc !== e.epc ||
            stat_branches !== e.ebr || stat_mispredicts !== e.emp ||
            clear_busy !== e.ebusy) begin
            bad++;
            $display("FAIL %s: got tk=%0b pc=%h br=%0d mp=%0d busy=%0b want tk=%0b pc=%h br=%0d mp=%0d busy=%0b",
                     e.name, predict_taken, predict_pc, stat_branches,
                     stat_mispredicts, clear_busy, e.etk, e.epc,
                     e.ebr, e.emp, e.ebusy);
        end
    endtask

    initial begin
        tbl.push_back(L("reset_dflt", 32'h100, 0, 32'h104, 0, 0, 0));
        tbl.push_back(U("same_cycle", 3'b100, 1, 1, 32'h100, 32'h80,
                        32'h100, 0, 32'h104, 0, 0));
        tbl.push_back(L("alloc_hit", 32'h100, 1, 32'h80, 1, 1, 0));
        tbl.push_back(U("nt1", 3'b100, 0, 1, 32'h100, 0, 32'h100,
                        1, 32'h80, 1, 1));
        tbl.push_back(U("nt2", 3'b100, 0, 0, 32'h100, 0, 32'h100,
                        0, 32'h104, 2, 2));
        tbl.push_back(U("nt3", 3'b100, 0, 0, 32'h100, 0, 32'h100,
                        0, 32'h104, 3, 2));
        tbl.push_back(U("nt4", 3'b100, 0, 0, 32'h100, 0, 32'h100,
                        0, 32'h104, 4, 2));
        tbl.push_back(U("nt5", 3'b100, 0, 0, 32'h100, 0, 32'h100,
                        0, 32'h104, 5, 2));
        tbl.push_back(U("tk_from_00", 3'b100, 1, 1, 32'h100, 32'h80,
                        32'h100, 0, 32'h104, 6, 2));
        tbl.push_back(L("sat_lo", 32'h100, 0, 32'h104, 7, 3, 0));
        tbl.push_back(U("jal_miss", 3'b010, 1, 1, 32'h200, 32'h400,
                        32'h200, 0, 32'h204, 7, 3));
        tbl.push_back(L("jal_hit", 32'h200, 1, 32'h400, 8, 4, 0));
        tbl.push_back(U("jalr_upd", 3'b001, 1, 1, 32'h300, 32'h500,
                        32'h300, 0, 32'h304, 8, 4));
        tbl.push_back(L("jalr_look", 32'h300, 0, 32'h304, 8, 4, 0));
        tbl.push_back(L("jalr_keep", 32'h200, 1, 32'h400, 8, 4, 0));
        tbl.push_back(U("no_type", 3'b000, 0, 1, 32'h200, 0,
                        32'h200, 1, 32'h400, 8, 4));
        tbl.push_back(U("prio_br", 3'b110, 1, 0, 32'h104, 32'h900,
                        32'h104, 0, 32'h108, 8, 4));
        tbl.push_back(U("prio_nt", 3'b100, 0, 0, 32'h104, 0,
                        32'h104, 1, 32'h900, 9, 4));
        tbl.push_back(L("prio_chk", 32'h104, 0, 32'h108, 10, 4, 0));
        tbl.push_back(U("alias_a", 3'b100, 1, 0, 32'h100, 32'h80,
                        32'h100, 0, 32'h104, 10, 4));
        tbl.push_back(U("alias_b", 3'b100, 1, 0, 32'h140, 32'hA0,
                        32'h100, 1, 32'h80, 11, 4));
        tbl.push_back(L("alias_miss", 32'h100, 0, 32'h104, 12, 4, 0));
        tbl.push_back(L("alias_new", 32'h140, 1, 32'hA0, 12, 4, 0));
        tbl.push_back(U("sat_hi1", 3'b100, 1, 0, 32'h140, 32'hC0,
                        32'h140, 1, 32'hA0, 12, 4));
        tbl.push_back(U("sat_hi2", 3'b100, 1, 0, 32'h140, 32'hC0,
                        32'h140, 1, 32'hC0, 13, 4));
        tbl.push_back(U("sat_hi_nt", 3'b100, 0, 0, 32'h140, 0,
                        32'h140, 1, 32'hC0, 14, 4));
        tbl.push_back(L("sat_hi_chk", 32'h140, 1, 32'hC0, 15, 4, 0));
        tbl.push_back(L("pc_wrap", 32'hFFFF_FFFC, 0, 32'h0, 15, 4, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(U("populate", 3'b100, 1, 0, 32'h108 + 4 * i,
                            32'h1000 + 16 * i, 32'h108 + 4 * i,
                            0, 32'h10C + 4 * i, 15 + i, 4));
        end
        tbl.push_back(L("pop_chk", 32'h108, 1, 32'h1000, 19, 4, 0));
        tbl.push_back(V("clr_go", 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h108,
                        1, 32'h1000, 19, 4, 0));
        for (int i = 0; i < 16; i++) begin
            tbl.push_back(V("clr_run", 0, 1, 1, 3'b100, 1, 1, 32'h108,
                            32'hDEAD_0000, 32'h10C, 0, 32'h110, 19, 4, 1));
        end
        for (int i = 0; i < 16; i++) begin
            tbl.push_back(L("post_clr", 32'h100 + 4 * i, 0,
                            32'h104 + 4 * i, 19, 4, 0));
        end
        tbl.push_back(U("jal_c", 3'b010, 1, 0, 32'h130, 32'h2000,
                        32'h130, 0, 32'h134, 19, 4));
        tbl.push_back(L("jal_c_chk", 32'h130, 1, 32'h2000, 20, 4, 0));
        tbl.push_back(V("clr_go2", 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h130,
                        1, 32'h2000, 20, 4, 0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(L("clr2_run", 32'h130, 0, 32'h134, 20, 4, 1));
        end
        tbl.push_back(V("rst_mid", 1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h130,
                        0, 32'h134, 20, 4, 1));
        tbl.push_back(L("rst_abort", 32'h130, 0, 32'h134, 0, 0, 0));
        tbl.push_back(V("rst_clr", 1, 1, 0, 3'b000, 0, 0, 0, 0, 32'h130,
                        0, 32'h134, 0, 0, 0));
        tbl.push_back(L("rst_wins", 32'h130, 0, 32'h134, 0, 0, 0));
        tbl.push_back(L("rst_wins2", 32'h130, 0, 32'h134, 0, 0, 0));

        reset          = 1'b1;
        clear_req      = 1'b0;
        upd_valid      = 1'b0;
        upd_is_branch  = 1'b0;
        upd_is_jump    = 1'b0;
        upd_is_jumpr   = 1'b0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        upd_pc         = '0;
        upd_target     = '0;
        if_pc          = '0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: got %0d left want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor supplying the branch prediction bit that the branch/jump unit compares against its resolved outcome. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It is looked up combinationally by the fetch stage and trained by the execute stage on every resolved branch or JAL. It also keeps branch and misprediction performance counters, and has a sequenced clear operation for fence.i / context switch.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width, derived; not overridden.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  32  fetch-stage PC to predict.
- predict_taken  output  1  predicted taken; feeds the branch_predict pipeline bit.
- predict_pc  output  32  next fetch PC: target on predicted taken, otherwise if_pc+4.
- upd_valid  input  1  one-cycle pulse; EX-stage resolution of a control-flow instruction.
- upd_pc  input  32  PC of the resolved instruction.
- upd_is_branch  input  1  conditional branch.
- upd_is_jump  input  1  JAL.
- upd_is_jumpr  input  1  JALR; never trained.
- upd_taken  input  1  resolved taken (branch_taken).
- upd_target  input  32  resolved target (branch_pc).
- upd_mispredict  input  1  resolved flush.
- clear_req  input  1  starts a full BTB invalidation.
- clear_busy  output  1  high while the clear sequence runs.
- stat_branches  output  32  count of trained branch/JAL updates.
- stat_mispredicts  output  32  count of updates with upd_mispredict set.

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0].
- Entry index = pc[IDX_W+1:2].
- **Lookup (combinational):**
  - hit = valid && tag match.
  - predict_taken = hit && ctr[1] && !clear_busy.
  - predict_pc = predict_taken ? target : if_pc + 32'd4 (mod 2^32).
- **Training:** occurs when upd_valid && (upd_is_branch || upd_is_jump) && !clear_busy.
  - Hit, taken: ctr increments, saturating at 2'b11; target <= upd_target.
  - Hit, not taken: ctr decrements, saturating at 2'b00; target unchanged.
  - Miss, taken: allocate (overwrite) the entry: valid=1, new tag, target=upd_target. ctr=2'b10 for a branch, ctr=2'b11 for a JAL.
  - Miss, not taken: no change.
- upd_is_jumpr, or upd_valid with no type flag set: the BTB is untouched and no stat increments.
- If more than one type flag is set, the priority is upd_is_branch, then upd_is_jump, then upd_is_jumpr.
- **Stats:**
  - stat_branches increments on every training update.
  - stat_mispredicts increments when the training update also has upd_mispredict.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Stats do not increment during a clear.
- **FSM states:** IDLE and CLEAR.
  - IDLE -> CLEAR when clear_req is high. The index counter is loaded with 0.
  - In CLEAR, one entry per cycle: valid <= 0, ctr <= 2'b01.
  - CLEAR -> IDLE after index ENTRIES-1 is written.
  - clear_req during CLEAR is ignored; there is no restart.
  - In CLEAR, upd_valid is dropped (no training) and predictions are forced not-taken.

## Timing
- Lookup latency is 0 cycles: a purely combinational path from if_pc to predict_taken/predict_pc.
- A training write is visible to lookups starting the cycle after upd_valid.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no bypass.
- clear_busy rises the cycle after clear_req is sampled and stays high for exactly ENTRIES cycles.
- **Reset (synchronous, active-high), effective at the next edge:**
  - All valid=0 and all ctr=2'b01.
  - Target and tag values are don't-care.
  - FSM=IDLE and the index counter is 0.
  - clear_busy=0, stat_branches=0, stat_mispredicts=0.
  - After reset, predict_taken=0 and predict_pc=if_pc+4.
- Reset asserted mid-CLEAR aborts the sequence. The block returns to IDLE with the full reset state.
- Reset and clear_req in the same cycle: reset wins, and clear_req is ignored.

## Test plan
- **Reset defaults:** assert reset, then set if_pc=32'h100 -> predict_taken=0, predict_pc=32'h104, both stats 0, clear_busy=0.
- **Branch allocate and saturate:**
  - Taken branch update at upd_pc=32'h100, upd_target=32'h80. Next cycle, if_pc=32'h100 -> taken, predict_pc=32'h80.
  - Two not-taken updates -> ctr=00, predict_pc=32'h104.
  - Three more not-taken updates -> ctr stays 00.
- **JAL vs JALR:**
  - JAL miss at 32'h200, target 32'h400 -> ctr=11, predicted taken next cycle.
  - JALR update at 32'h300 -> lookup of 32'h300 is not taken, and stat_branches increments only for the JAL.
- **Aliasing:**
  - Taken branch at 32'h100, then taken branch at 32'h100+(ENTRIES*4) -> the second overwrites the entry.
  - Lookup of 32'h100 then misses (predict_pc=32'h104).
- **Same-cycle lookup/update:** if_pc=upd_pc=32'h100 with the first taken update -> predict_taken=0 that cycle, and 1 on the next cycle.
- **Clear sequence:**
  - Populate 4 entries, then pulse clear_req -> clear_busy high for 16 cycles (ENTRIES=16).
  - Updates during the clear do not change the BTB or the stats. All lookups return not-taken afterwards.
  - Reset asserted at clear cycle 5 -> clear_busy=0 on the next cycle.
